mem_stage_ctrl: RTL and testbench

- Memory stage of the five-stage pipeline; consumer end of the execute→memory interface.
- Takes the flopped ALU result as address, store data and memory-control flops from execute.
- Drives a variable-latency word data memory through a req/done handshake and stalls upstream stages while an access is outstanding.
- Registers results, PC and halt/error status toward writeback (_3ff outputs).

---
 rtl/mem_stage_ctrl.sv | 136 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: issues word accesses to a variable-latency data memory,
// stalls upstream while an access is outstanding, and registers results toward writeback.
module mem_stage_ctrl #(
    parameter int          TIMEOUT  = 16,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ALU_Out,
    input  logic [15:0] WrData_2ff,
    input  logic [15:0] PC_2ff,
    input  logic        MemWrt_2ff,
    input  logic        MemRead_2ff,
    input  logic        Halt_2ff,
    input  logic        Valid_2ff,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        Stall,
    output logic [15:0] MemOut_3ff,
    output logic [15:0] ALU_Out_3ff,
    output logic [15:0] PC_3ff,
    output logic        Valid_3ff,
    output logic        Err_3ff,
    output logic        Halt_3ff
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, HALTED} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic          we_q;
    logic [15:0]   addr_q;
    logic [15:0]   wdata_q;
    logic          is_mem;
    logic          illegal;
    logic          issue;

    // NOTE: every always_comb output gets a value on every path so no latch is inferred.
    always_comb begin
        is_mem  = MemRead_2ff | MemWrt_2ff;
        illegal = Valid_2ff & is_mem & ((MemRead_2ff & MemWrt_2ff) | ALU_Out[0]);
        issue   = rst & (state == IDLE) & Valid_2ff & is_mem & ~illegal;
    end

    // The request cycle drives the bus straight from execute; BUSY replays the captured copy.
    assign mem_req   = issue;
    assign mem_we    = issue ? MemWrt_2ff : we_q;
    assign mem_addr  = issue ? ALU_Out    : addr_q;
    assign mem_wdata = issue ? WrData_2ff : wdata_q;
    assign Stall     = issue | ((state == BUSY) & ~mem_done) | (state == HALTED);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            MemOut_3ff  <= 16'h0000;
            ALU_Out_3ff <= 16'h0000;
            PC_3ff      <= RESET_PC;
            Valid_3ff   <= 1'b0;
            Err_3ff     <= 1'b0;
            Halt_3ff    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!Valid_2ff) begin
                        Valid_3ff <= 1'b0;
                        Err_3ff   <= 1'b0;
                    end else if (illegal) begin
                        PC_3ff    <= PC_2ff;
                        Valid_3ff <= 1'b1;
                        Err_3ff   <= 1'b1;
                        Halt_3ff  <= 1'b1;
                        state     <= HALTED;
                    end else if (is_mem) begin
                        we_q      <= MemWrt_2ff;
                        addr_q    <= ALU_Out;
                        wdata_q   <= WrData_2ff;
                        count     <= CW'(1);
                        Valid_3ff <= 1'b0;
                        Err_3ff   <= 1'b0;
                        state     <= BUSY;
                    end else begin
                        ALU_Out_3ff <= ALU_Out;
                        PC_3ff      <= PC_2ff;
                        MemOut_3ff  <= 16'h0000;
                        Valid_3ff   <= 1'b1;
                        Err_3ff     <= 1'b0;
                        if (Halt_2ff) begin
                            Halt_3ff <= 1'b1;
                            state    <= HALTED;
                        end
                    end
                end
                BUSY: begin
                    if (mem_done) begin
                        MemOut_3ff  <= MemRead_2ff ? mem_rdata : 16'h0000;
                        ALU_Out_3ff <= ALU_Out;
                        PC_3ff      <= PC_2ff;
                        Valid_3ff   <= 1'b1;
                        Err_3ff     <= 1'b0;
                        if (Halt_2ff) begin
                            Halt_3ff <= 1'b1;
                            state    <= HALTED;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (count == CW'(TIMEOUT)) begin
                        PC_3ff    <= PC_2ff;
                        Valid_3ff <= 1'b1;
                        Err_3ff   <= 1'b1;
                        Halt_3ff  <= 1'b1;
                        state     <= HALTED;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                HALTED: begin
                    Valid_3ff <= 1'b0;
                    Err_3ff   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected writeback results are queued when an
// instruction is driven and compared whenever Valid_3ff is seen.
module tb_mem_stage_ctrl;

    localparam int          TO  = 4;
    localparam logic [15:0] RPC = 16'h8000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ALU_Out = '0, WrData_2ff = '0, PC_2ff = '0, mem_rdata = '0;
    logic        MemWrt_2ff = 0, MemRead_2ff = 0, Halt_2ff = 0, Valid_2ff = 0, mem_done = 0;
    logic        mem_req, mem_we, Stall, Valid_3ff, Err_3ff, Halt_3ff;
    logic [15:0] mem_addr, mem_wdata, MemOut_3ff, ALU_Out_3ff, PC_3ff;

    mem_stage_ctrl #(.TIMEOUT(TO), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .ALU_Out(ALU_Out), .WrData_2ff(WrData_2ff), .PC_2ff(PC_2ff),
        .MemWrt_2ff(MemWrt_2ff), .MemRead_2ff(MemRead_2ff), .Halt_2ff(Halt_2ff),
        .Valid_2ff(Valid_2ff), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done), .Stall(Stall),
        .MemOut_3ff(MemOut_3ff), .ALU_Out_3ff(ALU_Out_3ff), .PC_3ff(PC_3ff),
        .Valid_3ff(Valid_3ff), .Err_3ff(Err_3ff), .Halt_3ff(Halt_3ff)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] alu;
        logic [15:0] pc;
        logic [15:0] memout;
        logic        err;
        logic        halt;
    } exp_t;

    exp_t        sb[$];
    exp_t        got;
    int          checks = 0;
    int          failures = 0;
    int          stall_cnt = 0;
    int          req_cnt = 0;
    logic        cap_we = 0;
    logic [15:0] cap_addr = '0, cap_wdata = '0;
    logic [15:0] m_alu = '0, m_mem = '0;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Falling-edge monitor: counts stalls and requests, and scores writeback results.
    always @(negedge clk) begin
        if (rst) begin
            if (Stall) stall_cnt++;
            if (mem_req) begin
                req_cnt++;
                cap_we    = mem_we;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
            end
            if (Valid_3ff) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_valid", 16'(Valid_3ff), 16'h0);
                end else begin
                    got = sb.pop_front();
                    check("sb_alu",    ALU_Out_3ff,       got.alu);
                    check("sb_pc",     PC_3ff,            got.pc);
                    check("sb_memout", MemOut_3ff,        got.memout);
                    check("sb_err",    16'(Err_3ff),      16'(got.err));
                    check("sb_halt",   16'(Halt_3ff),     16'(got.halt));
                end
            end
        end
    end

    task automatic clear_inputs();
        Valid_2ff = 0; MemRead_2ff = 0; MemWrt_2ff = 0; Halt_2ff = 0; mem_done = 0;
        ALU_Out = '0; WrData_2ff = '0; PC_2ff = '0; mem_rdata = '0;
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_req"},   16'(mem_req),   16'h0);
        check({tag, "_we"},    16'(mem_we),    16'h0);
        check({tag, "_addr"},  mem_addr,       16'h0);
        check({tag, "_wdata"}, mem_wdata,      16'h0);
        check({tag, "_stall"}, 16'(Stall),     16'h0);
        check({tag, "_mout"},  MemOut_3ff,     16'h0);
        check({tag, "_alu"},   ALU_Out_3ff,    16'h0);
        check({tag, "_pc"},    PC_3ff,         RPC);
        check({tag, "_valid"}, 16'(Valid_3ff), 16'h0);
        check({tag, "_err"},   16'(Err_3ff),   16'h0);
        check({tag, "_halt"},  16'(Halt_3ff),  16'h0);
    endtask

    // Entered and left at posedge+1; reset takes effect without a clock edge.
    task automatic do_reset(input string tag);
        rst = 0;
        clear_inputs();
        #1;
        reset_values(tag);
        sb.delete();
        m_alu = '0;
        m_mem = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic idle(input int n);
        clear_inputs();
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic nonmem(input logic [15:0] alu, input logic [15:0] pc, input string tag);
        exp_t e;
        ALU_Out = alu; PC_2ff = pc; MemRead_2ff = 0; MemWrt_2ff = 0; Halt_2ff = 0;
        Valid_2ff = 1;
        stall_cnt = 0;
        e = '{alu, pc, 16'h0, 1'b0, 1'b0};
        sb.push_back(e);
        m_alu = alu; m_mem = 16'h0;
        @(posedge clk); #1;
        check({tag, "_stall_cycles"}, 16'(stall_cnt), 16'h0);
    endtask

    task automatic memop(input logic rd, input logic wr, input logic halt, input logic early,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] pc, input logic [15:0] rdata,
                         input int lat, input string tag);
        exp_t e;
        ALU_Out = addr; WrData_2ff = wdata; PC_2ff = pc;
        MemRead_2ff = rd; MemWrt_2ff = wr; Halt_2ff = halt; Valid_2ff = 1;
        stall_cnt = 0; req_cnt = 0;
        if (early) begin
            mem_done = 1; mem_rdata = 16'hDEAD;
        end
        e = '{addr, pc, rd ? rdata : 16'h0, 1'b0, halt};
        sb.push_back(e);
        for (int i = 1; i <= lat; i++) begin
            @(posedge clk); #1;
            mem_done  = (i == lat);
            mem_rdata = (i == lat) ? rdata : 16'h0;
        end
        @(posedge clk); #1;
        clear_inputs();
        check({tag, "_req_pulses"},   16'(req_cnt),   16'h1);
        check({tag, "_we"},           16'(cap_we),    16'(wr));
        check({tag, "_addr"},         cap_addr,       addr);
        if (wr) check({tag, "_wdata"}, cap_wdata,     wdata);
        check({tag, "_stall_cycles"}, 16'(stall_cnt), 16'(lat));
        m_alu = addr; m_mem = e.memout;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset("rst0");

        // Pass-through, back-to-back, then a bubble that must hold the writeback data.
        nonmem(16'h1234, 16'h0040, "alu1");
        nonmem(16'h5678, 16'h0042, "alu2");
        idle(2);
        check("bubble_valid", 16'(Valid_3ff), 16'h0);
        check("bubble_hold",  ALU_Out_3ff,    m_alu);

        // Load with a done pulse in the request cycle that must be ignored.
        memop(1'b1, 1'b0, 1'b0, 1'b1, 16'h0100, 16'h0000, 16'h0044, 16'hBEEF, 3, "load");
        memop(1'b0, 1'b1, 1'b0, 1'b0, 16'h0200, 16'hA5A5, 16'h0046, 16'h7777, 1, "store");
        nonmem(16'h0F0F, 16'h0048, "alu3");
        idle(1);

        // Halt riding on a load takes effect only when the load completes.
        memop(1'b1, 1'b0, 1'b1, 1'b0, 16'h0500, 16'h0000, 16'h0080, 16'h1357, 2, "ldhalt");
        idle(3);
        check("ldhalt_stall", 16'(Stall),    16'h1);
        check("ldhalt_halt",  16'(Halt_3ff), 16'h1);
        do_reset("rst1");

        // Misaligned load: no request, error plus halt, stuck stalled.
        begin
            exp_t e;
            ALU_Out = 16'h0101; PC_2ff = 16'h0050; MemRead_2ff = 1; Valid_2ff = 1;
            req_cnt = 0;
            #1 check("mis_req_now", 16'(mem_req), 16'h0);
            e = '{m_alu, 16'h0050, m_mem, 1'b1, 1'b1};
            sb.push_back(e);
            @(posedge clk); #1;
            check("mis_err", 16'(Err_3ff), 16'h1);
            idle(3);
            check("mis_req_cnt", 16'(req_cnt),   16'h0);
            check("mis_stall",   16'(Stall),     16'h1);
            check("mis_valid",   16'(Valid_3ff), 16'h0);
            check("mis_halt",    16'(Halt_3ff),  16'h1);
        end
        do_reset("rst2");

        // Timeout: no done for TO BUSY cycles, then a late done must be ignored.
        begin
            exp_t e;
            ALU_Out = 16'h0300; PC_2ff = 16'h0060; MemRead_2ff = 1; Valid_2ff = 1;
            req_cnt = 0;
            e = '{m_alu, 16'h0060, m_mem, 1'b1, 1'b1};
            sb.push_back(e);
            for (int i = 1; i <= TO + 1; i++) begin
                @(posedge clk); #1;
                if (i <= TO) check("to_early_valid", 16'(Valid_3ff), 16'h0);
            end
            check("to_err",   16'(Err_3ff), 16'h1);
            mem_done = 1; mem_rdata = 16'h4444;
            @(posedge clk); #1;
            mem_done = 0;
            idle(3);
            check("to_req_cnt", 16'(req_cnt),    16'h1);
            check("to_stall",   16'(Stall),      16'h1);
            check("to_mout",    MemOut_3ff,      16'h0);
        end
        do_reset("rst3");

        // Reset in the middle of an access, then a stale done after release.
        ALU_Out = 16'h0400; PC_2ff = 16'h0070; MemRead_2ff = 1; Valid_2ff = 1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("mid_busy_stall", 16'(Stall), 16'h1);
        #2 rst = 0;
        #1 reset_values("mid_rst");
        clear_inputs();
        @(posedge clk); #1 rst = 1;
        req_cnt = 0;
        mem_done = 1; mem_rdata = 16'h9999;
        @(posedge clk); #1;
        mem_done = 0;
        check("stale_valid", 16'(Valid_3ff), 16'h0);
        idle(2);
        check("stale_stall", 16'(Stall),    16'h0);
        check("stale_req",   16'(req_cnt),  16'h0);
        check("stale_mout",  MemOut_3ff,    16'h0);

        check("sb_drained", 16'(sb.size()), 16'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
